// File: rtl/uart_sample_tx.sv
// rtl/uart_sample_tx.sv - decimate an 8-bit sample stream, buffer it and send it as 8N1 UART frames
//
// Ports:
//   sys_clk     system clock, rising edge
//   sys_rst     synchronous active-low reset
//   data_in     8-bit sample from signal selection
//   data_in_en  sample-valid qualifier (level)
//   tx_en       streaming enable; 0 stops capture and clears the decimation counter
//   uart_txd    serial output, idle high
//   tx_busy     high while a frame is on the line
//   fifo_ovf    sticky overflow flag, cleared only by reset
module uart_sample_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int UART_BPS   = 115200,
  parameter int DECIM      = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] data_in,
  input  logic       data_in_en,
  input  logic       tx_en,
  output logic       uart_txd,
  output logic       tx_busy,
  output logic       fifo_ovf
);

  localparam int BAUD_CNT = CLK_FREQ / UART_BPS;
  localparam int BW = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_CNT - 1);
  localparam logic [DW-1:0] DEC_LAST  = DW'(DECIM - 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_next;

  logic [DW-1:0] dec_cnt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic push, pop, push_ok, baud_done, txd_next;

  assign push      = tx_en && data_in_en && (dec_cnt == DEC_LAST);
  assign pop       = (state == IDLE) && (count != '0);
  // a push into a full FIFO still fits when the head leaves on the same edge
  assign push_ok   = push && ((count != FIFO_FULL) || pop);
  assign baud_done = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_next = state;
    txd_next   = 1'b1;
    case (state)
      IDLE:  if (pop) state_next = START;
      START: begin
        txd_next = 1'b0;
        if (baud_done) state_next = DATA;
      end
      DATA: begin
        txd_next = shift[bit_idx];
        if (baud_done && (bit_idx == 3'd7)) state_next = STOP;
      end
      STOP:  if (baud_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) state <= IDLE;
    else          state <= state_next;
  end

  // sample storage carries no reset; the pointers define what is valid
  always_ff @(posedge sys_clk) begin
    if (sys_rst && push_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      dec_cnt  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      fifo_ovf <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shift    <= 8'h00;
      uart_txd <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      // line and busy are registered from the state, so the start bit
      // appears one edge after the pop
      uart_txd <= txd_next;
      tx_busy  <= (state != IDLE);

      if (!tx_en)          dec_cnt <= '0;
      else if (data_in_en) dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + 1'b1;

      if (push && !push_ok) fifo_ovf <= 1'b1;
      if (push_ok)          wr_ptr   <= wr_ptr + 1'b1;
      if (pop)              rd_ptr   <= rd_ptr + 1'b1;

      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (pop) begin
        shift    <= mem[rd_ptr];
        baud_cnt <= '0;
        bit_idx  <= 3'd0;
      end else if (state != IDLE) begin
        if (baud_done) begin
          baud_cnt <= '0;
          if (state == DATA) bit_idx <= bit_idx + 1'b1;
        end else begin
          baud_cnt <= baud_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_sample_tx.sv
// tb/tb_uart_sample_tx.sv - self-checking bench for uart_sample_tx
module tb_uart_sample_tx;

  localparam int B     = 10;
  localparam int FRAME = 10 * B;

  logic       sys_clk;
  logic       sys_rst;
  logic [7:0] data_in;
  logic       data_in_en;
  logic       tx_en;
  logic       uart_txd;
  logic       tx_busy;
  logic       fifo_ovf;

  uart_sample_tx #(
    .CLK_FREQ(1_000_000),
    .UART_BPS(100_000),
    .DECIM(4),
    .FIFO_DEPTH(4)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .data_in(data_in),
    .data_in_en(data_in_en),
    .tx_en(tx_en),
    .uart_txd(uart_txd),
    .tx_busy(tx_busy),
    .fifo_ovf(fifo_ovf)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model: sample queue, decimation phase, and the frame in flight
  logic [7:0] m_q[$];
  int         m_dec    = 0;
  bit         m_ovf    = 0;
  bit         m_fvalid = 0;
  int         m_fstart = 0;
  logic [7:0] m_fbyte  = 8'h00;

  // recorded line for frame decoding
  bit   rec_line[$];
  int   busy_cnt = 0;
  logic [7:0] dec_bytes[$];
  int   dec_starts[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic te, input logic de, input logic [7:0] d);
    int  old_sz;
    bit  idle, do_pop, do_push;
    if (!r) begin
      m_q.delete();
      m_dec = 0; m_ovf = 0; m_fvalid = 0;
      return;
    end
    old_sz  = m_q.size();
    idle    = !m_fvalid || (cyc >= m_fstart + FRAME + 1);
    do_pop  = idle && (old_sz > 0);
    do_push = te && de && (m_dec == 3);
    if (!te)     m_dec = 0;
    else if (de) m_dec = (m_dec + 1) % 4;
    if (do_pop) begin
      m_fbyte  = m_q.pop_front();
      m_fstart = cyc;
      m_fvalid = 1;
    end
    if (do_push) begin
      if (old_sz == 4 && !do_pop) m_ovf = 1;
      else m_q.push_back(d);
    end
  endtask

  task automatic model_out(output logic txd, output logic busy);
    int k, b;
    k = cyc - m_fstart;
    txd = 1'b1; busy = 1'b0;
    if (m_fvalid && k >= 1 && k <= FRAME) begin
      b = (k - 1) / B;
      busy = 1'b1;
      if (b == 0)      txd = 1'b0;
      else if (b == 9) txd = 1'b1;
      else             txd = m_fbyte[b-1];
    end
  endtask

  task automatic tick(input logic r, input logic te, input logic de, input logic [7:0] d);
    logic et, eb;
    sys_rst = r; tx_en = te; data_in_en = de; data_in = d;
    @(posedge sys_clk);
    cyc++;
    model_edge(r, te, de, d);
    #1;
    model_out(et, eb);
    check("model_txd", {31'd0, uart_txd}, {31'd0, et});
    check("model_busy", {31'd0, tx_busy}, {31'd0, eb});
    check("model_ovf", {31'd0, fifo_ovf}, {31'd0, m_ovf});
    rec_line.push_back(uart_txd);
    if (tx_busy) busy_cnt++;
  endtask

  task automatic clear_rec();
    rec_line.delete();
    busy_cnt = 0;
  endtask

  // find start bits in the recorded line and sample each bit mid-cell
  task automatic decode();
    int i;
    logic [7:0] v;
    dec_bytes.delete();
    dec_starts.delete();
    i = 1;
    while (i + FRAME <= rec_line.size()) begin
      if (rec_line[i] == 1'b0 && rec_line[i-1] == 1'b1) begin
        for (int b = 0; b < 8; b++) v[b] = rec_line[i + B * (b + 1) + B / 2];
        dec_bytes.push_back(v);
        dec_starts.push_back(i);
        i += FRAME;
      end else begin
        i++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  typedef struct {
    logic       rst, te, de;
    logic [7:0] d;
    logic       txd, busy, ovf;
  } vec_t;

  vec_t tbl[21];

  initial begin
    sys_rst = 1'b0; tx_en = 1'b1; data_in_en = 1'b1; data_in = 8'hA5;

    // reset held 5 cycles, 4 qualified cycles, pop edge, start bit, first data bit
    for (int i = 0; i < 5; i++)   tbl[i] = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    for (int i = 5; i < 9; i++)   tbl[i] = '{1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    for (int i = 10; i < 20; i++) tbl[i] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[20] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};

    // reset values and single frame of A5
    clear_rec();
    for (int i = 0; i < 21; i++) begin
      tick(tbl[i].rst, tbl[i].te, tbl[i].de, tbl[i].d);
      check($sformatf("tbl%0d_txd", i), {31'd0, uart_txd}, {31'd0, tbl[i].txd});
      check($sformatf("tbl%0d_busy", i), {31'd0, tx_busy}, {31'd0, tbl[i].busy});
      check($sformatf("tbl%0d_ovf", i), {31'd0, fifo_ovf}, {31'd0, tbl[i].ovf});
    end
    idle(120);
    decode();
    check("single_busy_cycles", busy_cnt, FRAME);
    check("single_nframes", dec_bytes.size(), 1);
    if (dec_bytes.size() > 0) check("single_byte", dec_bytes[0], 8'hA5);

    // back-to-back frames
    clear_rec();
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b1, 8'h01);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b1, 8'h80);
    idle(230);
    decode();
    check("b2b_nframes", dec_bytes.size(), 2);
    if (dec_bytes.size() == 2) begin
      check("b2b_byte0", dec_bytes[0], 8'h01);
      check("b2b_byte1", dec_bytes[1], 8'h80);
      check("b2b_start_spacing", dec_starts[1] - dec_starts[0], FRAME + 1);
    end

    // overflow: sixth push (qualified cycle 24) is dropped
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    clear_rec();
    for (int j = 1; j <= 24; j++) begin
      tick(1'b1, 1'b1, 1'b1, 8'(j));
      if (j == 23) check("ovf_before", {31'd0, fifo_ovf}, 32'd0);
      if (j == 24) check("ovf_rise", {31'd0, fifo_ovf}, 32'd1);
    end
    idle(560);
    decode();
    check("ovf_sticky", {31'd0, fifo_ovf}, 32'd1);
    check("ovf_nframes", dec_bytes.size(), 5);
    for (int k = 0; k < 5 && k < dec_bytes.size(); k++)
      check($sformatf("ovf_byte%0d", k), dec_bytes[k], 8'(4 * (k + 1)));
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    check("ovf_reset_clear", {31'd0, fifo_ovf}, 32'd0);

    // tx_en dropped during the first of three queued frames
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    clear_rec();
    for (int j = 1; j <= 14; j++) tick(1'b1, 1'b1, 1'b1, 8'h10 + 8'(j));
    idle(16);
    for (int j = 0; j < 300; j++) tick(1'b1, 1'b0, 1'b1, 8'($urandom));
    decode();
    check("dis_nframes", dec_bytes.size(), 3);
    if (dec_bytes.size() == 3) begin
      check("dis_byte0", dec_bytes[0], 8'h14);
      check("dis_byte1", dec_bytes[1], 8'h18);
      check("dis_byte2", dec_bytes[2], 8'h1C);
    end
    clear_rec();
    for (int j = 0; j < 3; j++) tick(1'b1, 1'b1, 1'b1, 8'h55);
    idle(20);
    check("dis_restart_no_frame", busy_cnt, 0);
    tick(1'b1, 1'b1, 1'b1, 8'h55);
    idle(2);
    check("dis_restart_busy", {31'd0, tx_busy}, 32'd1);
    check("dis_restart_txd", {31'd0, uart_txd}, 32'd0);
    idle(110);

    // reset during data bit 3
    for (int j = 0; j < 4; j++) tick(1'b1, 1'b1, 1'b1, 8'h3C);
    idle(45);
    check("rstmid_busy_before", {31'd0, tx_busy}, 32'd1);
    tick(1'b0, 1'b1, 1'b1, 8'h3C);
    check("rstmid_txd", {31'd0, uart_txd}, 32'd1);
    check("rstmid_busy", {31'd0, tx_busy}, 32'd0);
    clear_rec();
    for (int j = 0; j < 3; j++) tick(1'b1, 1'b1, 1'b1, 8'h3C);
    idle(30);
    check("rstmid_no_frame", busy_cnt, 0);
    tick(1'b1, 1'b1, 1'b1, 8'h3C);
    idle(2);
    check("rstmid_new_frame", {31'd0, uart_txd}, 32'd0);
    idle(110);

    // randomized traffic against the model
    begin
      int  rate;
      logic te;
      te = 1'b1;
      rate = 2;
      for (int c = 0; c < 4000; c++) begin
        if (c % 500 == 0) rate = $urandom_range(0, 4);
        if ($urandom_range(0, 199) == 0) te = ~te;
        tick(($urandom_range(0, 1499) != 0), te,
             ($urandom_range(0, 3) < rate), 8'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
